// File: rtl/inst_issue_queue.sv
// Multi-lane instruction issue queue: circular buffer of {inst, pc} entries between fetch and decode.
// Optional macro IQ_STALL_STATS_EN adds a saturating fetch-stall cycle counter output (stall_cycles).
module inst_issue_queue #(
  parameter int LANES  = 2,
  parameter int DEPTH  = 16,
  parameter int INST_W = 32,
  parameter int PC_W   = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [$clog2(LANES+1)-1:0]     in_count,
  input  logic [LANES*INST_W-1:0]        in_inst,
  input  logic [PC_W-1:0]                in_pc,
  output logic                           in_ready,
  output logic [LANES-1:0]               out_valid,
  output logic [LANES*INST_W-1:0]        out_inst,
  output logic [LANES*PC_W-1:0]          out_pc,
  input  logic [$clog2(LANES+1)-1:0]     pop_count,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy
`ifdef IQ_STALL_STATS_EN
  ,
  output logic [31:0]                    stall_cycles
`endif
);

  localparam int CW = $clog2(LANES + 1);
  localparam int OW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]     head;
  logic [AW-1:0]     tail;
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem   [DEPTH];

  logic [OW-1:0]     free_slots;
  logic              push_en;
  logic [CW-1:0]     push_cnt;
  logic [CW-1:0]     pop_cl;
  logic [OW-1:0]     pop_eff;

  // Credit comes only from registered occupancy; same-cycle pops never free space for a push.
  always_comb begin
    free_slots = OW'(DEPTH) - occupancy;
    in_ready   = (free_slots >= OW'(LANES));
    push_en    = in_ready && !flush;
    push_cnt   = '0;
    if (push_en) begin
      push_cnt = (in_count > CW'(LANES)) ? CW'(LANES) : in_count;
    end
    pop_cl  = (pop_count > CW'(LANES)) ? CW'(LANES) : pop_count;
    pop_eff = (OW'(pop_cl) > occupancy) ? occupancy : OW'(pop_cl);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else begin
      head      <= head + AW'(pop_eff);
      tail      <= tail + AW'(push_cnt);
      occupancy <= occupancy + OW'(push_cnt) - pop_eff;
    end
  end

  // Storage is never cleared; stale entries are hidden by occupancy-gated outputs.
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < LANES; i++) begin
      if (CW'(i) < push_cnt) begin
        inst_mem[tail + AW'(i)] <= in_inst[(LANES-1-i)*INST_W +: INST_W];
        pc_mem[tail + AW'(i)]   <= in_pc + PC_W'(4 * i);
      end
    end
  end

  always_comb begin
    out_valid = '0;
    out_inst  = '0;
    out_pc    = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (occupancy > OW'(i)) begin
        out_valid[i]                          = 1'b1;
        out_inst[(LANES-1-i)*INST_W +: INST_W] = inst_mem[head + AW'(i)];
        out_pc[(LANES-1-i)*PC_W +: PC_W]       = pc_mem[head + AW'(i)];
      end
    end
  end

`ifdef IQ_STALL_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if ((in_count != '0) && !in_ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_issue_queue.sv
// Scoreboard bench for inst_issue_queue: driver queues hand-computed expectations, monitor pops and compares.
module tb_inst_issue_queue;

  logic        clock;
  logic        reset;
  logic        flush;
  logic [1:0]  in_count;
  logic [63:0] in_inst;
  logic [31:0] in_pc;
  logic        in_ready;
  logic [1:0]  out_valid;
  logic [63:0] out_inst;
  logic [63:0] out_pc;
  logic [1:0]  pop_count;
  logic [4:0]  occupancy;
`ifdef IQ_STALL_STATS_EN
  logic [31:0] stall_cycles;
`endif

  inst_issue_queue #(.LANES(2), .DEPTH(16), .INST_W(32), .PC_W(32)) dut (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .in_count(in_count),
    .in_inst(in_inst),
    .in_pc(in_pc),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_inst(out_inst),
    .out_pc(out_pc),
    .pop_count(pop_count),
    .occupancy(occupancy)
`ifdef IQ_STALL_STATS_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  typedef struct {
    int          id;
    int          occ;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [31:0] p0;
    logic [31:0] p1;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   vec_id   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Called at posedge+4; the expectation describes the state after the coming edge.
  task automatic step(input int cnt, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pc, input int pop, input bit fl,
                      input int eocc, input logic [31:0] ei0, input logic [31:0] ei1,
                      input logic [31:0] ep0, input logic [31:0] ep1);
    exp_t e;
    in_count  = 2'(cnt);
    in_inst   = {a, b};
    in_pc     = pc;
    pop_count = 2'(pop);
    flush     = fl;
    e.id  = vec_id;
    e.occ = eocc;
    e.i0  = ei0;
    e.i1  = ei1;
    e.p0  = ep0;
    e.p1  = ep1;
    exp_q.push_back(e);
    vec_id++;
    @(posedge clock);
    #4;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, " occupancy"}, 32'(occupancy), 32'd0);
    chk({tag, " in_ready"},  32'(in_ready),  32'd1);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " out_inst_hi"}, out_inst[63:32], 32'd0);
    chk({tag, " out_inst_lo"}, out_inst[31:0],  32'd0);
    chk({tag, " out_pc_hi"},   out_pc[63:32],   32'd0);
    chk({tag, " out_pc_lo"},   out_pc[31:0],    32'd0);
  endtask

  // Monitor: compares the DUT against each queued expectation shortly after the edge it refers to.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("v%0d occupancy", e.id), 32'(occupancy), 32'(e.occ));
        chk($sformatf("v%0d in_ready", e.id), 32'(in_ready), ((16 - e.occ) >= 2) ? 32'd1 : 32'd0);
        chk($sformatf("v%0d out_valid", e.id), 32'(out_valid),
            {30'd0, (e.occ > 1) ? 1'b1 : 1'b0, (e.occ > 0) ? 1'b1 : 1'b0});
        chk($sformatf("v%0d inst0", e.id), out_inst[63:32], e.i0);
        chk($sformatf("v%0d inst1", e.id), out_inst[31:0],  e.i1);
        chk($sformatf("v%0d pc0", e.id),   out_pc[63:32],   e.p0);
        chk($sformatf("v%0d pc1", e.id),   out_pc[31:0],    e.p1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_count  = '0;
    in_inst   = '0;
    in_pc     = '0;
    pop_count = '0;
    #12;
    chk_empty("reset");
    @(posedge clock);
    #4;
    reset = 1'b0;

    // First push right after reset release, then drain.
    step(2, 32'hA, 32'hB, 32'h100, 0, 0, 2, 32'hA, 32'hB, 32'h100, 32'h104);
    step(0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0);

    // Fill to capacity: entries n=1..16 with pc 0x200+4(n-1).
    for (int j = 0; j < 8; j++)
      step(2, 32'(2*j+1), 32'(2*j+2), 32'h200 + 32'(8*j), 0, 0,
           2*(j+1), 32'd1, 32'd2, 32'h200, 32'h204);
    step(2, 32'h99, 32'h9A, 32'h900, 0, 0, 16, 32'd1, 32'd2, 32'h200, 32'h204);
    step(2, 32'h77, 32'h78, 32'h700, 2, 0, 14, 32'd3, 32'd4, 32'h208, 32'h20C);

    for (int k = 1; k <= 6; k++)
      step(0, 0, 0, 0, 2, 0, 14 - 2*k, 32'(3+2*k), 32'(4+2*k),
           32'h200 + 32'(4*(2+2*k)), 32'h200 + 32'(4*(3+2*k)));
    step(0, 0, 0, 0, 1, 0, 1, 32'd16, 32'd0, 32'h23C, 32'd0);
    step(0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0);

    // Single-lane push shifts alignment to an odd slot before the wrap run.
    step(1, 32'h55, 32'hEE, 32'h500, 0, 0, 1, 32'h55, 32'd0, 32'h500, 32'd0);
    step(2, 32'h1000, 32'h1001, 32'h4000, 1, 0, 2, 32'h1000, 32'h1001, 32'h4000, 32'h4004);
    for (int c = 1; c <= 40; c++)
      step((c == 20) ? 3 : 2, 32'h1000 + 32'(2*c), 32'h1001 + 32'(2*c), 32'h4000 + 32'(8*c), 2, 0,
           2, 32'h1000 + 32'(2*c), 32'h1001 + 32'(2*c), 32'h4000 + 32'(8*c), 32'h4004 + 32'(8*c));

    // Build to 6 then flush with simultaneous push and pop.
    step(2, 32'h81, 32'h82, 32'h800, 0, 0, 4, 32'h1050, 32'h1051, 32'h4140, 32'h4144);
    step(2, 32'h83, 32'h84, 32'h808, 0, 0, 6, 32'h1050, 32'h1051, 32'h4140, 32'h4144);
    step(2, 32'h85, 32'h86, 32'h810, 1, 1, 0, 0, 0, 0, 0);
    step(2, 32'h61, 32'h62, 32'h600, 0, 0, 2, 32'h61, 32'h62, 32'h600, 32'h604);
    step(2, 32'h63, 32'h64, 32'h608, 0, 0, 4, 32'h61, 32'h62, 32'h600, 32'h604);

    // Reset mid-stream: outputs must clear with no clock edge.
    reset = 1'b1;
    #1;
    chk_empty("async_reset");
    @(posedge clock);
    #4;
    reset = 1'b0;

    for (int j = 0; j < 8; j++)
      step(2, 32'h300 + 32'(2*j), 32'h301 + 32'(2*j), 32'h3000 + 32'(8*j), 0, 0,
           2*(j+1), 32'h300, 32'h301, 32'h3000, 32'h3004);
    for (int j = 0; j < 5; j++)
      step(2, 32'hDD, 32'hDE, 32'hD00, 0, 0, 16, 32'h300, 32'h301, 32'h3000, 32'h3004);
`ifdef IQ_STALL_STATS_EN
    chk("stall_cycles_full", stall_cycles, 32'd5);
`endif
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
`ifdef IQ_STALL_STATS_EN
    chk("stall_cycles_flush", stall_cycles, 32'd5);
`endif

    in_count  = '0;
    pop_count = '0;
    flush     = 1'b0;
    repeat (3) @(posedge clock);
    #4;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inst_issue_queue.md
INST_ISSUE_QUEUE -- requirements
Module: inst_issue_queue

Interface
REQ-001 Parameter: LANES, default 2, issue/fetch width in instructions per cycle.
REQ-002 Parameter: DEPTH, default 16, entry count, power of 2, >= 2*LANES.
REQ-003 Parameter: INST_W, default 32, instruction width.
REQ-004 Parameter: PC_W, default 32, program-counter width.
REQ-005 clock  input  1  single clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 flush  input  1  branch-taken flush; discard all queued entries.
REQ-008 in_count  input  clog2(LANES+1)  number of valid fetch lanes this cycle, lanes 0..in_count-1.
REQ-009 in_inst  input  LANES*INST_W  fetched instructions, lane 0 in MSBs (oldest).
REQ-010 in_pc  input  PC_W  PC of lane 0; lane i PC = in_pc + 4*i.
REQ-011 in_ready  output  1  queue accepts a full LANES-wide push this cycle; fetch stall = !in_ready.
REQ-012 out_valid  output  LANES  bit i set when entry i (from head) exists.
REQ-013 out_inst  output  LANES*INST_W  head..head+LANES-1 instructions, lane 0 oldest.
REQ-014 out_pc  output  LANES*PC_W  PCs of presented instructions.
REQ-015 pop_count  input  clog2(LANES+1)  instructions consumed by decode this cycle (dual issue 2, dependency stall 1 or 0).
REQ-016 occupancy  output  clog2(DEPTH+1)  current entry count.

Function
REQ-017 Circular buffer of DEPTH {inst, pc} entries; head/tail pointers wrap modulo DEPTH.
REQ-018 in_ready = (DEPTH - occupancy) >= LANES, from registered occupancy only; pops in the same cycle grant no credit.
REQ-019 Push: when in_ready=1 and flush=0, lanes 0..in_count-1 written at tail in order; tail advances by in_count.
REQ-020 Push while in_ready=0: entire group dropped, no state change from push.
REQ-021 Pop: effective pop = min(pop_count, occupancy); head advances by effective pop; pop_count above occupancy is clamped, never underflows.
REQ-022 Simultaneous push and pop: occupancy_next = occupancy + pushed - popped.
REQ-023 Latency: entry written at edge N visible on outputs after edge N (one cycle, no bypass); empty queue pushed and popped same cycle pops nothing.
REQ-024 out_valid[i] = (occupancy > i); out_inst/out_pc lanes with out_valid[i]=0 driven all zero.
REQ-025 Outputs combinational from registered state only; no input-to-output combinational path.
REQ-026 flush=1: next edge head=tail=0, occupancy=0; flush overrides same-cycle push and pop.
REQ-027 in_count > LANES treated as LANES.

Reset
REQ-028 reset=1 asynchronously sets head=tail=0, occupancy=0, out_valid=0, out_inst=0, out_pc=0, in_ready=1.
REQ-029 Reset mid-operation discards all entries; storage contents need not clear but never appear on outputs.
REQ-030 First push accepted on the first rising edge after reset deasserts.

Configuration
REQ-031 Macro IQ_STALL_STATS_EN: defined adds output stall_cycles (32 bits), incremented each cycle in_count>0 and in_ready=0, saturating at all-ones, cleared by reset only (not flush).
REQ-032 Macro IQ_STALL_STATS_EN undefined: no stall_cycles port, no counter logic; all other behaviour identical.

Verification
REQ-033 Reset, then push in_count=2, in_pc=0x100, insts 0xA,0xB -> next cycle out_valid=2'b11, out_pc=0x100/0x104, occupancy=2.
REQ-034 Push 2/cycle with pop_count=0 for 7 cycles (DEPTH=16) -> occupancy=14, in_ready=1; 8th push -> occupancy=16, in_ready=0; 9th push dropped, occupancy stays 16.
REQ-035 Occupancy 16, push 2 and pop 2 same cycle -> push dropped (in_ready=0), occupancy=14, head lanes show entries 3,4.
REQ-036 Occupancy 1, pop_count=2 -> occupancy=0, out_valid=0, outputs zero; 40 push/pop cycles across wrap -> PCs strictly ordered.
REQ-037 Occupancy 6, flush with push 2 and pop 1 -> occupancy=0, out_valid=0; reset asserted mid-stream -> outputs zero immediately, without a clock edge.
REQ-038 IQ_STALL_STATS_EN defined, full queue with in_count=2 for 5 cycles -> stall_cycles=5; flush -> still 5.
